// File: rtl/fifo_rd_checker.sv
// FIFO read-side checker: drains BURST_LEN words per prog_full trigger and verifies the counter pattern.
// Optional statistics counters are enabled with the FIFO_RD_CHECKER_STATS_EN macro.
module fifo_rd_checker #(
  parameter int unsigned BURST_LEN = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 rd_clk_i,
  input  logic                 rst_i,
  input  logic                 rst_busy_i,
  input  logic                 prog_full_i,
  input  logic                 empty_i,
  input  logic                 rd_valid_i,
  input  logic [31:0]          rdata_i,
  input  logic                 stop_n_i,
  output logic                 rd_en_o,
  output logic                 rdata_error_o,
  output logic [31:0]          first_err_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    DRAIN     = 2'd2
  } state_e;

  localparam logic [16:0] BURST_LIMIT = 17'(BURST_LEN);

  state_e      state_q, state_d;
  logic        rd_en_q, rd_en_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [16:0] issued_s;
  logic        seeded_q, seeded_d;
  logic [15:0] prev_hi_q, prev_hi_d;
  logic        error_q, error_d;
  logic [31:0] first_err_q, first_err_d;
  logic        intra_ok_s, seq_ok_s, fail_s;

  // Read-issue FSM; issued_s counts reads including the one on the wire this cycle
  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    burst_cnt_d = burst_cnt_q;
    issued_s    = {1'b0, burst_cnt_q} + {16'd0, rd_en_q};
    if (rst_busy_i) begin
      state_d     = IDLE;
      burst_cnt_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          burst_cnt_d = 16'd0;
          if (prog_full_i) begin
            state_d = DRAIN;
            rd_en_d = ~empty_i & stop_n_i;
          end else begin
            state_d = WAIT_TRIG;
          end
        end
        DRAIN: begin
          burst_cnt_d = issued_s[15:0];
          if (issued_s >= BURST_LIMIT) begin
            state_d = WAIT_TRIG;
            rd_en_d = 1'b0;
          end else begin
            rd_en_d = ~empty_i & stop_n_i;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Pattern check on every valid word, independent of the FSM state
  always_comb begin
    intra_ok_s  = (rdata_i[15:0] == (rdata_i[31:16] + 16'd1));
    seq_ok_s    = ~seeded_q || (rdata_i[31:16] == (prev_hi_q + 16'd2));
    fail_s      = rd_valid_i & ~(intra_ok_s & seq_ok_s);
    seeded_d    = seeded_q;
    prev_hi_d   = prev_hi_q;
    error_d     = error_q | fail_s;
    first_err_d = first_err_q;
    if (rd_valid_i) begin
      seeded_d  = 1'b1;
      prev_hi_d = rdata_i[31:16];
    end else begin
      seeded_d  = seeded_q;
    end
    if (fail_s && !error_q) begin
      first_err_d = rdata_i;
    end else begin
      first_err_d = first_err_q;
    end
    if (rst_busy_i || (state_q == IDLE)) begin
      seeded_d = 1'b0;
    end else begin
      seeded_d = seeded_d;
    end
  end

  // State and check registers
  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      burst_cnt_q <= 16'd0;
      seeded_q    <= 1'b0;
      prev_hi_q   <= 16'd0;
      error_q     <= 1'b0;
      first_err_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      burst_cnt_q <= burst_cnt_d;
      seeded_q    <= seeded_d;
      prev_hi_q   <= prev_hi_d;
      error_q     <= error_d;
      first_err_q <= first_err_d;
    end
  end

  assign rd_en_o       = rd_en_q;
  assign rdata_error_o = error_q;
  assign first_err_o   = first_err_q;

`ifdef FIFO_RD_CHECKER_STATS_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  // Word count wraps; error count saturates at all-ones
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (rd_valid_i) begin
      word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      word_cnt_d = word_cnt_q;
    end
    if (fail_s && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      word_cnt_q <= {CNT_WIDTH{1'b0}};
      err_cnt_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
  assign err_cnt_o  = err_cnt_q;
`else
  assign word_cnt_o = {CNT_WIDTH{1'b0}};
  assign err_cnt_o  = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/fifo_rd_checker.md
FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

Interface
REQ-001 Parameter BURST_LEN, default 64, SHALL set the number of reads issued per drain burst; legal range 1..65535.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of word_cnt_o and err_cnt_o.
REQ-003 rd_clk_i  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 rst_i  in  1  SHALL be the reset, synchronous, active-high.
REQ-005 rst_busy_i  in  1  SHALL be the FIFO reset-busy flag, high while the FIFO is unusable.
REQ-006 prog_full_i  in  1  SHALL be the FIFO programmable-full flag, the drain trigger.
REQ-007 empty_i  in  1  SHALL be the FIFO empty flag.
REQ-008 rd_valid_i  in  1  SHALL mark rdata_i as valid.
REQ-009 rdata_i  in  32  SHALL be the FIFO read word: {older 16-bit sample, newer 16-bit sample}.
REQ-010 stop_n_i  in  1  SHALL pause reads while low (push button, active low).
REQ-011 rd_en_o  out  1  SHALL be the FIFO read enable, registered.
REQ-012 rdata_error_o  out  1  SHALL be the sticky pattern-error flag.
REQ-013 first_err_o  out  32  SHALL hold the first failing rdata_i.
REQ-014 word_cnt_o  out  CNT_WIDTH  SHALL count checked words.
REQ-015 err_cnt_o  out  CNT_WIDTH  SHALL count failing words.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_TRIG, DRAIN. Encoding is free.
REQ-017 IDLE SHALL go to WAIT_TRIG on the first cycle with rst_busy_i low.
REQ-018 WAIT_TRIG SHALL go to DRAIN on prog_full_i high and SHALL clear the burst counter.
REQ-019 In DRAIN, rd_en_o SHALL be 1 on the next cycle only when all of these hold: empty_i=0, stop_n_i=1, rd_en_o not already at burst limit. Otherwise it SHALL be 0.
REQ-020 Each cycle with rd_en_o=1 SHALL increment the burst counter.
REQ-021 When the burst counter reaches BURST_LEN, rd_en_o SHALL drop on the next edge and the FSM SHALL return to WAIT_TRIG.
REQ-022 The FIFO read latency is 1 cycle: rd_valid_i follows rd_en_o by one clock. The checker SHALL act on rd_valid_i only, never on rd_en_o.
REQ-023 empty_i high mid-burst SHALL hold DRAIN with rd_en_o=0; reads resume when empty_i falls, and the burst count is preserved.
REQ-024 Pattern check on a valid word:
  - rdata_i[15:0] SHALL equal rdata_i[31:16]+1 mod 2^16.
  - rdata_i[31:16] SHALL equal the previous valid word's [31:16]+2 mod 2^16.
  - The first valid word after reset or IDLE SHALL seed the sequence and check the intra-word rule only.
REQ-025 The 16-bit sequence SHALL wrap: word 32'hFFFF_0000 (after seed 32'hFFFD_FFFE) SHALL pass.
REQ-026 A failing word SHALL set rdata_error_o the next cycle; rdata_error_o SHALL clear only on rst_i.
REQ-027 first_err_o SHALL capture only the first failing word after reset.
REQ-028 After any word (pass or fail), the expected sequence SHALL resync to that word's [31:16]. One corrupt word therefore yields at most two errors.
REQ-029 rd_valid_i outside DRAIN SHALL still be checked.
REQ-030 rst_busy_i high in any state SHALL force IDLE, rd_en_o=0 and reseed. Error flags SHALL be held.

Reset
REQ-031 On rst_i: FSM=IDLE, rd_en_o=0, rdata_error_o=0, first_err_o=0, word_cnt_o=0, err_cnt_o=0, burst counter=0, seed flag cleared.
REQ-032 rst_i SHALL take priority over every other input, including mid-burst.

Configuration
REQ-033 Macro FIFO_RD_CHECKER_STATS_EN defined:
  - word_cnt_o SHALL increment per valid word and wrap.
  - err_cnt_o SHALL increment per failing word and saturate at all-ones.
REQ-034 Macro FIFO_RD_CHECKER_STATS_EN undefined: word_cnt_o and err_cnt_o SHALL be constant 0 and no counter flops SHALL be inferred. All other behaviour is unchanged.

Verification
REQ-035 Reset release, rst_busy_i=1 for 10 cycles then 0 -> rd_en_o stays 0 until prog_full_i=1; first rd_en_o the cycle after prog_full_i.
REQ-036 BURST_LEN=64, FIFO model never empty, words {2k,2k+1} -> exactly 64 rd_en_o cycles, FSM back in WAIT_TRIG, rdata_error_o=0, word_cnt_o=64.
REQ-037 empty_i=1 for 5 cycles after 10 reads -> rd_en_o=0 for those cycles; total reads still 64.
REQ-038 Inject 32'h0010_0013 in a good stream -> rdata_error_o=1 one cycle later, first_err_o=32'h0010_0013, err_cnt_o=1.
REQ-039 Sequence through 32'hFFFE_FFFF then 32'h0000_0001 -> no error (wrap).
REQ-040 stop_n_i=0 mid-burst, then rst_i pulse -> rd_en_o=0 while paused; after rst_i all outputs equal the REQ-031 values.
